// File: rtl/fir_seq_mac.sv
// Sequential FIR filter: one shared multiplier walks all taps per accepted sample.
// Define FIR_SAT_EN to clamp the rounded result to DW bits; otherwise it wraps.
module fir_seq_mac #(
  parameter int unsigned DW    = 16,
  parameter int unsigned CW    = 16,
  parameter int unsigned TAPS  = 13,
  parameter int unsigned SHIFT = 15,
  localparam int unsigned IW   = $clog2(TAPS),
  // Address is wide enough to express out-of-range tap numbers so they can be rejected
  localparam int unsigned AW   = $clog2(TAPS + 1),
  localparam int unsigned ACCW = DW + CW + $clog2(TAPS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] data_in,
  input  logic          coef_we,
  input  logic [AW-1:0] coef_addr,
  input  logic [CW-1:0] coef_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] data_out,
  output logic          busy
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMac  = 2'd1;
  localparam logic [1:0] StOut  = 2'd2;

  localparam logic [IW-1:0]        LastIdx = IW'(TAPS - 1);
  localparam logic [AW:0]          TapsA   = (AW + 1)'(TAPS);
  localparam logic signed [ACCW:0] Half    = (ACCW + 1)'(1) << (SHIFT - 1);

  logic [1:0]             state_q, state_d;
  logic signed [DW-1:0]   x_q    [TAPS];
  logic signed [DW-1:0]   x_d    [TAPS];
  logic signed [CW-1:0]   coef_q [TAPS];
  logic signed [CW-1:0]   coef_d [TAPS];
  logic signed [ACCW-1:0] acc_q, acc_d, acc_sum;
  logic [IW-1:0]          idx_q, idx_d;
  logic [DW-1:0]          data_out_q, data_out_d;
  logic signed [DW+CW-1:0] prod;
  logic signed [ACCW:0]   rnd;
  logic [DW-1:0]          narrow;
  logic                   coef_wr;

  assign coef_wr = coef_we && (state_q == StIdle) && ({1'b0, coef_addr} < TapsA);

  assign prod    = (DW + CW)'(x_q[idx_q]) * (DW + CW)'(coef_q[idx_q]);
  assign acc_sum = acc_q + {{(ACCW - DW - CW){prod[DW+CW-1]}}, prod};
  // One guard bit so the rounding offset cannot overflow the accumulator
  assign rnd     = {acc_sum[ACCW-1], acc_sum} + Half;

`ifdef FIR_SAT_EN
  logic signed [ACCW:0] shr;
  logic                 ovf;

  always_comb begin
    shr = rnd >>> SHIFT;
    ovf = !((&shr[ACCW:DW-1]) || !(|shr[ACCW:DW-1]));
    if (ovf) begin
      narrow = shr[ACCW] ? {1'b1, {(DW - 1){1'b0}}} : {1'b0, {(DW - 1){1'b1}}};
    end else begin
      narrow = shr[DW-1:0];
    end
  end
`else
  assign narrow = DW'(rnd >>> SHIFT);
`endif

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    coef_d     = coef_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    data_out_d = data_out_q;

    // Applied before the MAC starts, so a same-edge accept sees the new coefficient
    if (coef_wr) begin
      coef_d[coef_addr[IW-1:0]] = coef_data;
    end

    case (state_q)
      StIdle: begin
        if (in_valid) begin
          for (int unsigned k = 1; k < TAPS; k++) begin
            x_d[k] = x_q[k-1];
          end
          x_d[0]  = data_in;
          acc_d   = '0;
          idx_d   = '0;
          state_d = StMac;
        end
      end
      StMac: begin
        acc_d = acc_sum;
        idx_d = idx_q + IW'(1);
        if (idx_q == LastIdx) begin
          data_out_d = narrow;
          idx_d      = '0;
          state_d    = StOut;
        end
      end
      StOut: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      idx_q      <= '0;
      data_out_q <= '0;
      for (int unsigned k = 0; k < TAPS; k++) begin
        x_q[k]    <= '0;
        coef_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      data_out_q <= data_out_d;
      x_q        <= x_d;
      coef_q     <= coef_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StOut);
  assign busy      = (state_q == StMac) || (state_q == StOut);
  assign data_out  = data_out_q;

endmodule

// File: tb/tb_fir_seq_mac.sv
// Self-checking bench for fir_seq_mac (DW=16, CW=16, TAPS=4, SHIFT=2) against an arithmetic
// FIR model; honours FIR_SAT_EN when it is defined for the build.
module tb_fir_seq_mac;
  localparam int DW    = 16;
  localparam int CW    = 16;
  localparam int TAPS  = 4;
  localparam int SHIFT = 2;
  localparam int AW    = $clog2(TAPS + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] data_in = '0;
  logic          coef_we = 1'b0;
  logic [AW-1:0] coef_addr = '0;
  logic [CW-1:0] coef_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] data_out;
  logic          busy;

  int     tests = 0;
  int     fails = 0;
  int     cyc = 0;
  int     acc_cyc = 0;
  int     prev_acc = 0;
  longint x_m [TAPS];
  longint c_m [TAPS];

  fir_seq_mac #(.DW(DW), .CW(CW), .TAPS(TAPS), .SHIFT(SHIFT)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_out();
    longint acc = 0;
    longint r;
    for (int i = 0; i < TAPS; i++) acc += x_m[i] * c_m[i];
    r = (acc + (64'sd1 <<< (SHIFT - 1))) >>> SHIFT;
`ifdef FIR_SAT_EN
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
`endif
    return r[DW-1:0];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < TAPS; i++) begin
      x_m[i] = 0;
      c_m[i] = 0;
    end
  endtask

  // All tasks start and end on a falling edge
  task automatic write_coef(input int a, input int v);
    coef_we   = 1'b1;
    coef_addr = a[AW-1:0];
    coef_data = v[CW-1:0];
    @(posedge clk);
    if (a < TAPS) c_m[a] = $signed(v[CW-1:0]);
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic do_accept(input int d, input logic we, input int wa, input int wv);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready before accept", {31'b0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    data_in   = d[DW-1:0];
    coef_we   = we;
    coef_addr = wa[AW-1:0];
    coef_data = wv[CW-1:0];
    @(posedge clk);
    if (we && wa < TAPS) c_m[wa] = $signed(wv[CW-1:0]);
    for (int k = TAPS - 1; k > 0; k--) x_m[k] = x_m[k-1];
    x_m[0] = $signed(d[DW-1:0]);
    @(negedge clk);
    in_valid = 1'b0;
    coef_we  = 1'b0;
    prev_acc = acc_cyc;
    acc_cyc  = cyc;
  endtask

  // Counts rising edges from the accept edge (as 1) to the edge raising out_valid
  task automatic wait_out(input string tag);
    int n = 1;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, n, TAPS + 1);
    chk({tag, " data"}, {16'b0, data_out}, {16'b0, model_out()});
  endtask

  task automatic complete(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, " out_valid drop"}, {31'b0, out_valid}, 32'd0);
    chk({tag, " data_out held"}, {16'b0, data_out}, {16'b0, model_out()});
  endtask

  task automatic run(input int d, input string tag);
    do_accept(d, 1'b0, 0, 0);
    wait_out(tag);
    complete(tag);
  endtask

  initial begin
    int ovf_exp;
    model_clear();

    // Reset state
    #2 reset = 1'b0;
    #1;
    chk("reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset data_out", {16'b0, data_out}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    chk("in_ready after reset", {31'b0, in_ready}, 32'd1);

    // Impulse response, back-to-back samples
    for (int i = 0; i < TAPS; i++) write_coef(i, i + 1);
    for (int i = 0; i < 5; i++) begin
      run((i == 0) ? 4 : 0, "impulse");
      if (i > 0) chk("throughput", acc_cyc - prev_acc, TAPS + 2);
    end

    // Out-of-range write in IDLE, then writes held during MAC/OUT: both ignored
    write_coef(5, 77);
    do_accept(4, 1'b0, 0, 0);
    coef_we   = 1'b1;
    coef_addr = '0;
    coef_data = 16'd100;
    wait_out("ignored writes");
    coef_we = 1'b0;
    complete("ignored writes");
    for (int i = 0; i < 3; i++) run(0, "ignored writes");

    // Backpressure: output held, nothing accepted while stalled
    out_ready = 1'b0;
    do_accept(9, 1'b0, 0, 0);
    wait_out("backpressure");
    in_valid = 1'b1;
    data_in  = 16'd1234;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall out_valid", {31'b0, out_valid}, 32'd1);
      chk("stall data_out", {16'b0, data_out}, {16'b0, model_out()});
      chk("stall in_ready", {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    complete("backpressure");
    run(0, "after stall");

    // Random coefficients and samples; one coefficient write coincides with an accept
    for (int i = 0; i < TAPS; i++) write_coef(i, int'($urandom_range(0, 65535)));
    for (int i = 0; i < 8; i++) begin
      do_accept(int'($urandom_range(0, 65535)), (i == 3), i % TAPS,
                int'($urandom_range(0, 65535)));
      wait_out("random");
      complete("random");
    end

    // Overflow of the narrowed result
`ifdef FIR_SAT_EN
    ovf_exp = 32'h7FFF;
`else
    ovf_exp = 32'hC000;
`endif
    write_coef(0, 32767);
    for (int i = 1; i < TAPS; i++) write_coef(i, 0);
    do_accept(32767, 1'b0, 0, 0);
    wait_out("overflow");
    chk("overflow literal", {16'b0, data_out}, ovf_exp);
    complete("overflow");

    // Sign and round-half-up
    write_coef(0, -1);
    do_accept(-8, 1'b0, 0, 0);
    wait_out("round -8");
    chk("round -8 literal", {16'b0, data_out}, 32'd2);
    complete("round -8");
    do_accept(-7, 1'b0, 0, 0);
    wait_out("round -7");
    chk("round -7 literal", {16'b0, data_out}, 32'd2);
    complete("round -7");

    // Reset two cycles into a MAC
    for (int i = 0; i < TAPS; i++) write_coef(i, i + 1);
    do_accept(4, 1'b0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midreset out_valid", {31'b0, out_valid}, 32'd0);
    chk("midreset busy", {31'b0, busy}, 32'd0);
    chk("midreset data_out", {16'b0, data_out}, 32'd0);
    model_clear();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    chk("midreset in_ready", {31'b0, in_ready}, 32'd1);
    do_accept(4, 1'b0, 0, 0);
    wait_out("post-reset impulse");
    chk("post-reset literal", {16'b0, data_out}, 32'd0);
    complete("post-reset impulse");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
